// File: rtl/semaphore_monitor.sv
// semaphore_monitor: passive checker for the traffic-light lamp outputs.
// Registers the lamps, decodes the phase, and flags undecodable lamp
// combinations, out-of-order phase changes and wrong dwell times. It also
// counts error cycles and completed GREEN->RED cycles.
module semaphore_monitor #(
   parameter int RED_CYCLES    = 51,
   parameter int YELLOW_CYCLES = 11,
   parameter int GREEN_CYCLES  = 20,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             red,
   input  logic             yellow,
   input  logic             green,
   output logic [3:0]       phase_out,
   output logic             err_illegal,
   output logic             err_sequence,
   output logic             err_timing,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] cycles_done
);

   localparam logic [2:0] ST_OFF     = 3'd0;
   localparam logic [2:0] ST_RED     = 3'd1;
   localparam logic [2:0] ST_YELLOW  = 3'd2;
   localparam logic [2:0] ST_GREEN   = 3'd3;
   localparam logic [2:0] ST_UNKNOWN = 3'd4;

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] RED_EXP    = CNT_W'(RED_CYCLES);
   localparam logic [CNT_W-1:0] YELLOW_EXP = CNT_W'(YELLOW_CYCLES);
   localparam logic [CNT_W-1:0] GREEN_EXP  = CNT_W'(GREEN_CYCLES);

   logic [2:0]       s_lamp_q, s_lamp_d;
   logic [2:0]       cur_q, cur_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             partial_q, partial_d;
   logic             overrun_q, overrun_d;
   logic             err_illegal_q, err_illegal_d;
   logic             err_sequence_q, err_sequence_d;
   logic             err_timing_q, err_timing_d;
   logic             err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [CNT_W-1:0] cycles_done_q, cycles_done_d;

   logic [2:0]       dec;
   logic [CNT_W-1:0] exp_dwell;
   logic             cur_timed;
   logic             legal;
   logic             any_err;

   // Decode the registered lamps into a phase; any multi-lamp pattern is UNKNOWN.
   always_comb begin
      s_lamp_d = {red, yellow, green};
      case (s_lamp_q)
         3'b000:  dec = ST_OFF;
         3'b100:  dec = ST_RED;
         3'b010:  dec = ST_YELLOW;
         3'b001:  dec = ST_GREEN;
         default: dec = ST_UNKNOWN;
      endcase
   end

   // Nominal dwell of the current phase and whether that phase is timed at all.
   always_comb begin
      exp_dwell = '0;
      cur_timed = 1'b1;
      case (cur_q)
         ST_RED:    exp_dwell = RED_EXP;
         ST_YELLOW: exp_dwell = YELLOW_EXP;
         ST_GREEN:  exp_dwell = GREEN_EXP;
         default:   cur_timed = 1'b0;
      endcase
   end

   // Transition legality: the normal ring, disable to OFF, and recovery from UNKNOWN.
   always_comb begin
      legal = (cur_q == ST_UNKNOWN) || (dec == ST_OFF) ||
              ((cur_q == ST_OFF)    && (dec == ST_RED))    ||
              ((cur_q == ST_RED)    && (dec == ST_YELLOW)) ||
              ((cur_q == ST_YELLOW) && (dec == ST_GREEN))  ||
              ((cur_q == ST_GREEN)  && (dec == ST_RED));
   end

   // Phase tracking, dwell counting and error detection.
   always_comb begin
      cur_d          = cur_q;
      dwell_d        = dwell_q;
      partial_d      = partial_q;
      overrun_d      = overrun_q;
      err_illegal_d  = 1'b0;
      err_sequence_d = 1'b0;
      err_timing_d   = 1'b0;
      cycles_done_d  = cycles_done_q;
      if (dec != cur_q) begin
         // Phase entry: restart dwell; a phase entered from UNKNOWN has an
         // unknown start time, so it is marked partial and never timed.
         cur_d     = dec;
         dwell_d   = {{(CNT_W-1){1'b0}}, 1'b1};
         partial_d = (cur_q == ST_UNKNOWN);
         overrun_d = 1'b0;
         if (dec == ST_UNKNOWN) begin
            err_illegal_d = 1'b1;
         end else if (!legal) begin
            err_sequence_d = 1'b1;
         end else if ((dec != ST_OFF) && cur_timed && !partial_q && !overrun_q) begin
            // Exit check; an overrun phase was already reported by the timeout.
            if (dwell_q != exp_dwell) begin
               err_timing_d = 1'b1;
            end else if ((cur_q == ST_GREEN) && (dec == ST_RED)) begin
               cycles_done_d = cycles_done_q + 1'b1;
            end
         end
      end else begin
         if (dwell_q != CNT_MAX) begin
            dwell_d = dwell_q + 1'b1;
         end
         if (dec == ST_UNKNOWN) begin
            err_illegal_d = 1'b1;
         end
         // Phase still held after its full nominal dwell: report the overrun once.
         if (cur_timed && !partial_q && !overrun_q && (dwell_q == exp_dwell)) begin
            err_timing_d = 1'b1;
            overrun_d    = 1'b1;
         end
      end
   end

   // Error aggregation: one count per cycle with any error, saturating.
   always_comb begin
      any_err      = err_illegal_d | err_sequence_d | err_timing_d;
      err_sticky_d = err_sticky_q | any_err;
      err_count_d  = err_count_q;
      if (any_err && (err_count_q != CNT_MAX)) begin
         err_count_d = err_count_q + 1'b1;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_lamp_q       <= 3'b000;
         cur_q          <= ST_OFF;
         dwell_q        <= '0;
         partial_q      <= 1'b0;
         overrun_q      <= 1'b0;
         err_illegal_q  <= 1'b0;
         err_sequence_q <= 1'b0;
         err_timing_q   <= 1'b0;
         err_sticky_q   <= 1'b0;
         err_count_q    <= '0;
         cycles_done_q  <= '0;
      end else begin
         s_lamp_q       <= s_lamp_d;
         cur_q          <= cur_d;
         dwell_q        <= dwell_d;
         partial_q      <= partial_d;
         overrun_q      <= overrun_d;
         err_illegal_q  <= err_illegal_d;
         err_sequence_q <= err_sequence_d;
         err_timing_q   <= err_timing_d;
         err_sticky_q   <= err_sticky_d;
         err_count_q    <= err_count_d;
         cycles_done_q  <= cycles_done_d;
      end
   end

   // One-hot phase output from the tracked state.
   always_comb begin
      case (cur_q)
         ST_OFF:    phase_out = 4'b0001;
         ST_RED:    phase_out = 4'b0010;
         ST_YELLOW: phase_out = 4'b0100;
         ST_GREEN:  phase_out = 4'b1000;
         default:   phase_out = 4'b0000;
      endcase
   end

   assign err_illegal  = err_illegal_q;
   assign err_sequence = err_sequence_q;
   assign err_timing   = err_timing_q;
   assign err_sticky   = err_sticky_q;
   assign err_count    = err_count_q;
   assign cycles_done  = cycles_done_q;

endmodule

// File: tb/tb_semaphore_monitor.sv
// tb_semaphore_monitor: directed lamp sequences with hand-computed expectations.
module tb_semaphore_monitor;

   localparam logic [2:0] L_OFF = 3'b000;
   localparam logic [2:0] L_R   = 3'b100;
   localparam logic [2:0] L_Y   = 3'b010;
   localparam logic [2:0] L_G   = 3'b001;
   localparam logic [2:0] L_RG  = 3'b101;

   logic       clk;
   logic       rst;
   logic       red, yellow, green;
   logic [3:0] phase_out;
   logic       err_illegal, err_sequence, err_timing, err_sticky;
   logic [7:0] err_count, cycles_done;

   int n_checks = 0;
   int n_pass   = 0;

   // Running totals of pulses / UNKNOWN cycles, sampled on the falling edge.
   int tot_ill = 0, tot_seq = 0, tot_tim = 0, tot_unk = 0;
   int b_ill, b_seq, b_tim, b_unk;

   semaphore_monitor #(
      .RED_CYCLES(51), .YELLOW_CYCLES(11), .GREEN_CYCLES(20), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst),
      .red(red), .yellow(yellow), .green(green),
      .phase_out(phase_out),
      .err_illegal(err_illegal), .err_sequence(err_sequence), .err_timing(err_timing),
      .err_sticky(err_sticky), .err_count(err_count), .cycles_done(cycles_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count pulses away from the active edge.
   always @(negedge clk) begin
      tot_ill <= tot_ill + int'(err_illegal);
      tot_seq <= tot_seq + int'(err_sequence);
      tot_tim <= tot_tim + int'(err_timing);
      tot_unk <= tot_unk + int'(phase_out == 4'b0000);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
         $display("ok   %s: got %0d", tag, got);
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Hold one lamp pattern for n captured samples; ends 1 time unit after an edge.
   task automatic drive(input logic [2:0] l, input int n);
      {red, yellow, green} = l;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      b_ill = tot_ill; b_seq = tot_seq; b_tim = tot_tim; b_unk = tot_unk;
   endtask

   task automatic nominal_cycle();
      drive(L_R, 51);
      drive(L_Y, 11);
      drive(L_G, 20);
   endtask

   initial begin
      rst = 1'b1;
      {red, yellow, green} = L_OFF;
      #1;
      check("rst_phase", int'(phase_out), 1);
      check("rst_errs", int'({err_illegal, err_sequence, err_timing, err_sticky}), 0);
      check("rst_err_count", int'(err_count), 0);
      check("rst_cycles", int'(cycles_done), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Nominal: three full cycles, checking the 2-edge latency on the first RED.
      drive(L_OFF, 3);
      snap();
      {red, yellow, green} = L_R;
      @(posedge clk); #1;
      check("lat_edge1_phase", int'(phase_out), 1);
      @(posedge clk); #1;
      check("lat_edge2_phase", int'(phase_out), 2);
      drive(L_R, 49);
      drive(L_Y, 11);
      drive(L_G, 20);
      nominal_cycle();
      nominal_cycle();
      drive(L_R, 5);
      check("nom_cycles", int'(cycles_done), 3);
      check("nom_pulses", (tot_ill - b_ill) + (tot_seq - b_seq) + (tot_tim - b_tim), 0);
      check("nom_sticky", int'(err_sticky), 0);
      check("nom_phase", int'(phase_out), 2);

      // YELLOW short by one: single timing pulse at YELLOW->GREEN, cycle still counts.
      snap();
      drive(L_R, 46);
      drive(L_Y, 10);
      drive(L_G, 1);
      drive(L_G, 1);
      check("yshort_pulse", int'(err_timing), 1);
      drive(L_G, 18);
      drive(L_R, 5);
      check("yshort_tim", tot_tim - b_tim, 1);
      check("yshort_seq", tot_seq - b_seq, 0);
      check("yshort_err_count", int'(err_count), 1);
      check("yshort_sticky", int'(err_sticky), 1);
      check("yshort_cycles", int'(cycles_done), 4);

      // GREEN held 30: pulse when the 21st sample is processed, none at exit.
      snap();
      drive(L_R, 46);
      drive(L_Y, 11);
      drive(L_G, 20);
      drive(L_G, 1);
      check("gover_pre", int'(err_timing), 0);
      drive(L_G, 1);
      check("gover_pulse", int'(err_timing), 1);
      drive(L_G, 8);
      drive(L_R, 5);
      check("gover_tim", tot_tim - b_tim, 1);
      check("gover_cycles", int'(cycles_done), 4);
      check("gover_err_count", int'(err_count), 2);

      // red+green for 3 cycles mid-RED, then a partial RED of 51 and a clean cycle.
      snap();
      drive(L_R, 10);
      drive(L_RG, 3);
      check("ill_phase", int'(phase_out), 0);
      check("ill_pulse", int'(err_illegal), 1);
      drive(L_R, 51);
      drive(L_Y, 11);
      drive(L_G, 20);
      drive(L_R, 5);
      check("ill_count", tot_ill - b_ill, 3);
      check("ill_unk_cycles", tot_unk - b_unk, 3);
      check("ill_seq", tot_seq - b_seq, 0);
      check("ill_tim", tot_tim - b_tim, 0);
      check("ill_err_count", int'(err_count), 5);
      check("ill_cycles", int'(cycles_done), 5);

      // Partial phase skips the dwell check: RED of 30 after UNKNOWN is not an error.
      snap();
      drive(L_RG, 1);
      drive(L_R, 30);
      drive(L_Y, 11);
      drive(L_G, 20);
      drive(L_R, 5);
      check("part_tim", tot_tim - b_tim, 0);
      check("part_ill", tot_ill - b_ill, 1);
      check("part_err_count", int'(err_count), 6);
      check("part_cycles", int'(cycles_done), 6);

      // RED -> GREEN skips YELLOW: sequence error only; GREEN is then checked normally.
      snap();
      drive(L_R, 46);
      drive(L_G, 20);
      drive(L_R, 5);
      check("skip_seq", tot_seq - b_seq, 1);
      check("skip_tim", tot_tim - b_tim, 0);
      check("skip_err_count", int'(err_count), 7);
      check("skip_cycles", int'(cycles_done), 7);

      // Lamps off mid-YELLOW, OFF for 10, then a nominal cycle: no errors.
      snap();
      drive(L_R, 46);
      drive(L_Y, 5);
      drive(L_OFF, 10);
      check("off_phase", int'(phase_out), 1);
      nominal_cycle();
      drive(L_R, 5);
      check("off_pulses", (tot_ill - b_ill) + (tot_seq - b_seq) + (tot_tim - b_tim), 0);
      check("off_cycles", int'(cycles_done), 8);
      check("off_err_count", int'(err_count), 7);

      // Asynchronous reset mid-RED clears everything before the next edge.
      drive(L_R, 10);
      rst = 1'b1;
      #1;
      check("arst_phase", int'(phase_out), 1);
      check("arst_sticky", int'(err_sticky), 0);
      check("arst_err_count", int'(err_count), 0);
      check("arst_cycles", int'(cycles_done), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Resumes from OFF: one clean cycle counts from zero.
      snap();
      drive(L_OFF, 2);
      nominal_cycle();
      drive(L_R, 3);
      check("resume_cycles", int'(cycles_done), 1);
      check("resume_pulses", (tot_ill - b_ill) + (tot_seq - b_seq) + (tot_tim - b_tim), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/semaphore_monitor.md
# semaphore_monitor

Passive checker for the lamp outputs of the traffic-light FSM. It samples `red`/`yellow`/`green`, decodes the current phase, checks the sequence and per-phase dwell times against the controller's nominal timing, and reports faults and completed cycles. It sits on the lamp bus beside the controller, in a testbench or as an on-chip safety monitor, and never drives the lamps.

## Interface
- `RED_CYCLES`, 51, required RED dwell in clk cycles
- `YELLOW_CYCLES`, 11, required YELLOW dwell in clk cycles
- `GREEN_CYCLES`, 20, required GREEN dwell in clk cycles
- `CNT_W`, 8, width of dwell, cycle and error counters

- `clk`  in  1  sole clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `red`  in  1  red lamp from controller
- `yellow`  in  1  yellow lamp from controller
- `green`  in  1  green lamp from controller
- `phase_out`  out  4  one-hot decoded phase: 0001 OFF, 0010 RED, 0100 YELLOW, 1000 GREEN, 0000 UNKNOWN
- `err_illegal`  out  1  one-cycle pulse: lamp combination not decodable
- `err_sequence`  out  1  one-cycle pulse: illegal phase transition
- `err_timing`  out  1  one-cycle pulse: dwell mismatch or overrun
- `err_sticky`  out  1  set on any error pulse, cleared only by `rst`
- `err_count`  out  CNT_W  cycles with at least one error pulse, saturating
- `cycles_done`  out  CNT_W  completed GREEN->RED cycles, wraps at 2^CNT_W

## Operation
- Stage 1: `{red,yellow,green}` registered into `s_lamp` every edge; reset value 000.
- Decode of `s_lamp`: 000 OFF, 100 RED, 010 YELLOW, 001 GREEN, anything else UNKNOWN.
- State register `cur` (OFF/RED/YELLOW/GREEN/UNKNOWN) drives `phase_out`; reset value OFF.
- Dwell counter `dwell`: set to 1 when `cur` changes, incremented while decode == `cur`, saturates at 2^CNT_W-1.
- Flag `partial`: set on entry to any phase from UNKNOWN; cleared on the next phase entry. A partial phase skips dwell checks and does not count.
- Flag `overrun`: set when the timeout fires; cleared on the next phase entry.
- Legal transitions: OFF->RED, RED->YELLOW, YELLOW->GREEN, GREEN->RED, any->OFF, UNKNOWN->any.
- Other transitions between decodable phases: `err_sequence` pulses; `cur` still follows the decode; the new phase is checked normally.
- Decode UNKNOWN: `err_illegal` pulses on every cycle it persists; `cur` becomes UNKNOWN; no sequence error on entry or exit.
- Exit check applies only on a legal transition to RED, YELLOW or GREEN, with `partial` = 0 and `overrun` = 0:
  - `err_timing` pulses if `dwell` != the expected value for the phase being left.
  - Leaving to OFF never checks dwell (disable mid-phase is legal).
- Timeout: `dwell` == expected, decode still equals `cur`, and `partial` = 0 -> `err_timing` pulses once and `overrun` is set. No second timing error at exit.
- `cycles_done` increments on a legal GREEN->RED when the GREEN exit check passes (no timing error, not partial, not overrun).
- `err_count` increments by 1 per cycle in which any error pulses, whatever the number of simultaneous errors; saturates at 2^CNT_W-1.
- A sequence error and a timing error never fire on the same transition, because timing is checked only on legal transitions.

## Timing
- Lamp change captured into `s_lamp` at edge N; `phase_out`, error pulses and counters update at edge N+1. Latency from input change is 2 edges.
- `dwell` at the exit check equals the number of cycles the phase was held at the lamps.
- Error pulses are registered, high for exactly one cycle per event; only `err_illegal` repeats while its cause persists.
- `rst` asserted clears immediately, without waiting for a clock edge: `s_lamp` 000, `cur` OFF (`phase_out` 0001), `dwell` 0, all flags 0, all error outputs 0, `err_count` 0, `cycles_done` 0.
- On release of `rst`, operation resumes from OFF at the next edge.

## Test plan
- Nominal: OFF, then 3x (RED 51, YELLOW 11, GREEN 20), then RED -> no error pulses, `cycles_done` = 3, `phase_out` trails the lamps by 2 edges.
- YELLOW held 10 cycles in an otherwise nominal cycle -> one `err_timing` pulse at the YELLOW->GREEN update, `err_count` = 1, `err_sticky` = 1; GREEN->RED still counts.
- GREEN held 30 cycles -> `err_timing` pulse when the 21st GREEN sample is processed, no pulse at GREEN->RED, `cycles_done` unchanged.
- `red`+`green` driven 3 cycles mid-RED, then RED for 51 cycles, then YELLOW -> 3 consecutive `err_illegal` pulses, `phase_out` 0000 for 3 cycles, `err_count` +3; no `err_sequence`; no timing check on the RED->YELLOW exit (partial phase).
- RED 51 -> GREEN directly -> one `err_sequence`, no `err_timing`; then GREEN 20 -> RED increments `cycles_done`.
- Lamps off after 5 YELLOW cycles, OFF for 10 cycles, then a nominal cycle -> no errors. Then assert `rst` mid-RED -> all outputs reach reset values before the next edge.
